// File: rtl/bus_xfer_ctrl.sv
// Bus transfer sequencer: queues register-to-register transfer requests and issues
// one-hot load-to-bus / write strobes in a fixed DRIVE -> WRITE -> DONE sequence.
module bus_xfer_ctrl #(
    parameter  int unsigned NREG  = 8,
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 16,
    localparam int unsigned IW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [IW-1:0]   req_src,
    input  logic [IW-1:0]   req_dst,
    output logic [NREG-1:0] ldbus,
    output logic [NREG-1:0] wr,
    input  logic [W-1:0]    bus_in,
    output logic [W-1:0]    xfer_data,
    output logic            done,
    output logic            busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, DRIVE, WRITE, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2*IW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic [IW-1:0]   cur_src;
    logic [IW-1:0]   cur_dst;
    logic            push;
    logic            pop;

    // Ready comes straight from the registered count, so a same-cycle pop never frees a full FIFO.
    assign req_ready = (count < CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= {req_src, req_dst};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_src   <= '0;
            cur_dst   <= '0;
            xfer_data <= '0;
        end else begin
            if (pop) begin
                {cur_src, cur_dst} <= fifo_mem[rptr];
            end
            if (state == WRITE) begin
                xfer_data <= bus_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (count != '0) state_nxt = DRIVE;
            DRIVE:   state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode only registered state; indices >= NREG match no bit and stay silent.
    always_comb begin
        ldbus = '0;
        wr    = '0;
        done  = (state == DONE);
        busy  = (state != IDLE) || (count != '0);
        for (int unsigned i = 0; i < NREG; i++) begin
            if (((state == DRIVE) || (state == WRITE)) && (cur_src == IW'(i))) begin
                ldbus[i] = 1'b1;
            end
            if ((state == WRITE) && (cur_dst == IW'(i)) && (cur_src != cur_dst)) begin
                wr[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: models eight bus-attached registers, queues expected
// transfers on accept and checks strobes, data and timing when done pulses.
module tb_bus_xfer_ctrl;

    localparam logic [15:0] INIT [8] = '{16'h1234, 16'h2B6E, 16'hA5C3, 16'h3C3C,
                                         16'h7E81, 16'h0F0F, 16'hC001, 16'h5A5A};

    typedef struct {
        logic [2:0]  src;
        logic [2:0]  dst;
        logic [15:0] data;
        int unsigned acc;
        bit          lat;
        bit          gap;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_src;
    logic [2:0]  req_dst;
    logic [7:0]  ldbus;
    logic [7:0]  wr;
    logic [15:0] bus_in;
    logic [15:0] xfer_data;
    logic        done;
    logic        busy;

    logic [15:0] regs [8];
    logic [15:0] mdl [8];
    exp_t        sb [$];
    int unsigned cyc;
    int unsigned n_chk;
    int unsigned n_fail;

    bus_xfer_ctrl #(.NREG(8), .DEPTH(4), .W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .ldbus     (ldbus),
        .wr        (wr),
        .bus_in    (bus_in),
        .xfer_data (xfer_data),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file on the far side of the bus
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (rst) regs[i] <= INIT[i];
            else if (wr[i]) regs[i] <= bus_in;
        end
    end

    always_comb begin
        bus_in = '0;
        for (int i = 0; i < 8; i++) begin
            if (ldbus[i]) bus_in = bus_in | regs[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [2:0] s, input logic [2:0] d, input bit lat, input bit gap,
                        output int unsigned acc);
        exp_t e;
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        chk("accept", {31'b0, req_ready}, 32'd1);
        acc = cyc + 1;
        if (req_ready) begin
            e.src  = s;
            e.dst  = d;
            e.data = mdl[s];
            e.acc  = acc;
            e.lat  = lat;
            e.gap  = gap;
            sb.push_back(e);
            if (s != d) mdl[d] = mdl[s];
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && busy; k++) @(negedge clk);
        chk("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    // Monitor: pops one expectation per done pulse
    initial begin : monitor
        logic [7:0]  h1_ld, h1_wr, h2_ld, h2_wr, oh_s, oh_d;
        int unsigned last_done;
        exp_t        e;
        h1_ld = '0; h1_wr = '0; h2_ld = '0; h2_wr = '0;
        last_done = 0;
        forever begin
            @(negedge clk);
            chk("onehot", {30'b0, $onehot0(ldbus), $onehot0(wr)}, 32'h3);
            if (done === 1'b1) begin
                chk("done_has_entry", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e    = sb.pop_front();
                    oh_s = 8'b1 << e.src;
                    oh_d = (e.src == e.dst) ? 8'b0 : (8'b1 << e.dst);
                    chk("drive_ldbus", {24'b0, h2_ld}, {24'b0, oh_s});
                    chk("drive_wr", {24'b0, h2_wr}, 32'd0);
                    chk("write_ldbus", {24'b0, h1_ld}, {24'b0, oh_s});
                    chk("write_wr", {24'b0, h1_wr}, {24'b0, oh_d});
                    chk("done_strobes", {16'b0, ldbus, wr}, 32'd0);
                    chk("xfer_data", {16'b0, xfer_data}, {16'b0, e.data});
                    if (e.lat) chk("latency", cyc, e.acc + 3);
                    if (e.gap) chk("done_gap", cyc - last_done, 32'd4);
                end
                last_done = cyc;
            end
            h2_ld = h1_ld; h2_wr = h1_wr;
            h1_ld = ldbus; h1_wr = wr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned a0, a1, a2, a3, a4, a5;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        for (int i = 0; i < 8; i++) mdl[i] = INIT[i];

        // Reset and idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_strobes", {16'b0, ldbus, wr}, 32'd0);
        chk("rst_done_busy", {30'b0, done, busy}, 32'd0);
        chk("rst_xfer_data", {16'b0, xfer_data}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", {13'b0, ldbus, wr, done, busy, req_ready}, 32'd1);
        end

        // Single transfer 2 -> 5
        send(3'd2, 3'd5, 1'b1, 1'b0, a0);
        wait_idle();
        chk("single_xfer_data", {16'b0, xfer_data}, 32'hA5C3);
        chk("single_dst_reg", {16'b0, regs[5]}, 32'hA5C3);

        // FIFO full: first request goes in flight, the next four fill the FIFO
        send(3'd1, 3'd4, 1'b1, 1'b0, a0);
        send(3'd4, 3'd6, 1'b0, 1'b1, a1);
        send(3'd6, 3'd0, 1'b0, 1'b1, a2);
        send(3'd0, 3'd7, 1'b0, 1'b1, a3);
        chk("ready_count3", {31'b0, req_ready}, 32'd1);
        send(3'd7, 3'd3, 1'b0, 1'b1, a4);
        chk("ready_full", {31'b0, req_ready}, 32'd0);
        send(3'd3, 3'd1, 1'b0, 1'b1, a5);
        chk("held_accept", a5, a4 + 2);
        wait_idle();

        // src == dst
        send(3'd3, 3'd3, 1'b1, 1'b0, a0);
        wait_idle();
        chk("self_reg_kept", {16'b0, regs[3]}, {16'b0, mdl[3]});

        // Reset during WRITE of the first of three queued requests
        send(3'd6, 3'd2, 1'b1, 1'b0, a0);
        send(3'd2, 3'd7, 1'b0, 1'b1, a1);
        send(3'd7, 3'd4, 1'b0, 1'b1, a2);
        chk("in_write_ldbus", {24'b0, ldbus}, 32'h40);
        chk("in_write_wr", {24'b0, wr}, 32'h04);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_strobes", {16'b0, ldbus, wr}, 32'd0);
        chk("midrst_done_busy", {30'b0, done, busy}, 32'd0);
        chk("midrst_xfer_data", {16'b0, xfer_data}, 32'd0);
        chk("midrst_ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = INIT[i];
        repeat (20) @(negedge clk);
        chk("post_rst_idle", {30'b0, done, busy}, 32'd0);

        // Push coinciding with the IDLE pop while count == 2
        send(3'd5, 3'd2, 1'b1, 1'b0, a0);
        send(3'd2, 3'd6, 1'b0, 1'b1, a1);
        send(3'd6, 3'd1, 1'b0, 1'b1, a2);
        repeat (2) @(negedge clk);
        chk("pop_cycle_idle", {15'b0, ldbus, wr, done}, 32'd0);
        chk("pop_cycle_busy", {31'b0, busy}, 32'd1);
        send(3'd1, 3'd0, 1'b0, 1'b1, a3);
        chk("push_on_pop", a3, a0 + 5);
        send(3'd0, 3'd5, 1'b0, 1'b1, a4);
        send(3'd4, 3'd4, 1'b0, 1'b1, a5);
        chk("count_after_pp", a5, a0 + 7);
        chk("full_after_pp", {31'b0, req_ready}, 32'd0);
        wait_idle();

        repeat (8) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
